// File: rtl/sim_result_mailbox.sv
// rtl/sim_result_mailbox.sv - AHB-Lite result/console mailbox; optional watchdog via SIM_MAILBOX_WATCHDOG_EN
module sim_result_mailbox #(
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        sim_done,
  output logic        sim_pass,
  output logic [15:0] sim_code,
  output logic        overflow
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [8:0] DEPTH_C = 9'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t         state_q, state_d;
  logic           acc_q, write_q;
  logic [1:0]     addr_q;
  logic           wr_any, wr_char, wr_status, rd_data;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [8:0]     count_q;
  logic           overflow_q;
  logic           full, pop, push_ok;
  logic [15:0]    code_q;
  logic           timed_out;
  logic           expire;
  logic           unused_bus;

  assign HREADYOUT  = 1'b1;
  assign HRESP      = 1'b0;
  assign unused_bus = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[30:16]};

  // Capture the address phase; the transfer acts in the following data phase
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 2'd0;
    end else begin
      acc_q   <= HSEL & HREADY & HTRANS[1];
      write_q <= HWRITE;
      addr_q  <= HADDR[3:2];
    end
  end

  assign wr_any    = acc_q & write_q;
  assign wr_char   = wr_any & (addr_q == 2'd0);
  assign wr_status = wr_any & (addr_q == 2'd1) & HWDATA[31];
  assign rd_data   = acc_q & ~write_q;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign full       = (count_q == DEPTH_C);
  assign pop        = char_valid & char_ready;
  assign push_ok    = wr_char & (~full | pop);
  assign char_valid = (count_q != 9'd0);
  assign char_data  = char_valid ? mem[rd_ptr_q] : 8'h00;

  // Console byte storage; contents are only observed while count is non-zero
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr_q] <= HWDATA[7:0];
  end

  // FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 9'd0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 9'd1;
        2'b01:   count_q <= count_q - 9'd1;
        default: count_q <= count_q;
      endcase
      if (wr_char & full & ~pop) overflow_q <= 1'b1;
    end
  end

`ifdef SIM_MAILBOX_WATCHDOG_EN
  logic [31:0] wdog_q;

  // Watchdog counts idle RUN cycles; any mailbox write restarts it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog_q <= 32'd0;
    end else if (state_q == S_RUN) begin
      if (wr_any) wdog_q <= 32'd0;
      else        wdog_q <= wdog_q + 32'd1;
    end
  end

  assign expire = (state_q == S_RUN) & ~wr_any & (wdog_q == TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_wdog;
  assign unused_wdog = ^TIMEOUT_CYCLES;
  assign expire      = 1'b0;
`endif

  // Result state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // First result wins: DONE and TIMEOUT hold until reset
  always_comb begin
    state_d = state_q;
    if (state_q == S_RUN) begin
      if (wr_status)   state_d = S_DONE;
      else if (expire) state_d = S_TIMEOUT;
    end
  end

  // Result flags decoded from the state and latched code
  always_comb begin
    sim_done  = (state_q != S_RUN);
    timed_out = (state_q == S_TIMEOUT);
    sim_pass  = (state_q == S_DONE) & (code_q == 16'h0000);
  end

  // Result code is loaded only on the transition out of RUN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      code_q <= 16'h0000;
    end else if (state_q == S_RUN) begin
      if (wr_status)   code_q <= HWDATA[15:0];
      else if (expire) code_q <= 16'hDEAD;
    end
  end

  assign sim_code = code_q;
  assign overflow = overflow_q;

  // Zero-wait read mux driven from registered state during the data phase
  always_comb begin
    HRDATA = 32'h0000_0000;
    if (rd_data) begin
      case (addr_q)
        2'd1:    HRDATA = {sim_done, sim_pass, timed_out, 13'b0, code_q};
        2'd2:    HRDATA = {overflow_q, 22'b0, count_q};
        default: HRDATA = 32'h0000_0000;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_result_mailbox.sv
// tb/tb_sim_result_mailbox.sv - directed self-checking bench for sim_result_mailbox
module tb_sim_result_mailbox;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'h0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = 32'h0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready = 1'b0;
  logic        sim_done, sim_pass, overflow;
  logic [15:0] sim_code;

  int checks = 0;
  int errors = 0;

  sim_result_mailbox #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(32'd100)) dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .char_valid(char_valid),
    .char_data(char_data), .char_ready(char_ready), .sim_done(sim_done),
    .sim_pass(sim_pass), .sim_code(sim_code), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; char_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Address phase at one negedge, data phase at the next; returns once the write has acted
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge CLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(negedge CLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(negedge CLK);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge CLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(negedge CLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    #1 data = HRDATA;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    @(negedge CLK);
    checks++;
    if ({HRDATA, char_valid, char_data, sim_done, sim_pass, sim_code, overflow, HREADYOUT, HRESP} !==
        {32'h0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got valid=%0b data=%h done=%0b pass=%0b code=%h ovf=%0b hrdata=%h want all zero, hreadyout=1",
               char_valid, char_data, sim_done, sim_pass, sim_code, overflow, HRDATA);
    end
    bus_read(32'h8, rd);
    checks++;
    if (rd !== 32'h0000_0000) begin errors++; $display("FAIL reset_level got %h want 00000000", rd); end
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_0000) begin errors++; $display("FAIL reset_status got %h want 00000000", rd); end
  endtask

  task automatic test_console();
    logic [31:0] rd;
    do_reset();
    bus_write(32'h0, 32'h0000_0048);
    bus_write(32'h0, 32'h0000_0069);
    bus_read(32'h8, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL console_level got %h want 00000002", rd); end
    bus_read(32'h0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL char_read got %h want 00000000", rd); end
    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'hC, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reg3_read got %h want 00000000", rd); end
    @(negedge CLK);
    checks++;
    if (char_valid !== 1'b1 || char_data !== 8'h48) begin
      errors++; $display("FAIL console_head got valid=%0b data=%h want 1/48", char_valid, char_data);
    end
    char_ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (char_valid !== 1'b1 || char_data !== 8'h69) begin
      errors++; $display("FAIL console_second got valid=%0b data=%h want 1/69", char_valid, char_data);
    end
    @(negedge CLK);
    char_ready = 1'b0;
    checks++;
    if (char_valid !== 1'b0) begin errors++; $display("FAIL console_empty got valid=%0b want 0", char_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    do_reset();
    for (int i = 0; i < 17; i++) bus_write(32'h0, 32'(i));
    bus_read(32'h8, rd);
    checks++;
    if (rd !== 32'h8000_0010) begin errors++; $display("FAIL full_level got %h want 80000010", rd); end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag got %0b want 1", overflow); end
    // Push into a full FIFO while popping the head in the same cycle
    @(negedge CLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
    @(negedge CLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h55; char_ready = 1'b1;
    @(negedge CLK);
    char_ready = 1'b0;
    bus_read(32'h8, rd);
    checks++;
    if (rd !== 32'h8000_0010) begin errors++; $display("FAIL pushpop_level got %h want 80000010", rd); end
    @(negedge CLK);
    char_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] exp_b;
      exp_b = (k == 15) ? 8'h55 : 8'(k + 1);
      checks++;
      if (char_valid !== 1'b1 || char_data !== exp_b) begin
        errors++; $display("FAIL drain_%0d got valid=%0b data=%h want 1/%h", k, char_valid, char_data, exp_b);
      end
      @(negedge CLK);
    end
    char_ready = 1'b0;
    checks++;
    if (char_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("FAIL drain_end got valid=%0b ovf=%0b want 0/1", char_valid, overflow);
    end
  endtask

  task automatic test_result_pass();
    logic [31:0] rd;
    do_reset();
    bus_write(32'h4, 32'h0000_0007);
    checks++;
    if (sim_done !== 1'b0) begin errors++; $display("FAIL status_nobit31 got done=%0b want 0", sim_done); end
    bus_write(32'h4, 32'h8000_0000);
    checks++;
    if ({sim_done, sim_pass, sim_code} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL result_pass got done=%0b pass=%0b code=%h want 1/1/0000", sim_done, sim_pass, sim_code);
    end
    bus_write(32'h4, 32'h8000_0005);
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'hC000_0000 || sim_code !== 16'h0000 || sim_pass !== 1'b1) begin
      errors++; $display("FAIL first_wins got status=%h code=%h pass=%0b want C0000000/0000/1", rd, sim_code, sim_pass);
    end
    bus_write(32'h0, 32'h0000_0021);
    checks++;
    if (char_valid !== 1'b1 || char_data !== 8'h21) begin
      errors++; $display("FAIL char_after_done got valid=%0b data=%h want 1/21", char_valid, char_data);
    end
  endtask

  task automatic test_result_fail_and_reset();
    logic [31:0] rd;
    do_reset();
    bus_write(32'h4, 32'h8000_0042);
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h8000_0042 || sim_pass !== 1'b0 || sim_code !== 16'h0042) begin
      errors++; $display("FAIL result_fail got status=%h pass=%0b code=%h want 80000042/0/0042", rd, sim_pass, sim_code);
    end
    bus_write(32'h0, 32'h0000_0031);
    // Reset lands mid data phase of another CHAR write
    @(negedge CLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
    @(negedge CLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h77;
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({sim_done, sim_pass, sim_code, char_valid, char_data, overflow} !== {1'b0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0}) begin
      errors++; $display("FAIL async_reset got done=%0b pass=%0b code=%h valid=%0b data=%h ovf=%0b want all zero",
                         sim_done, sim_pass, sim_code, char_valid, char_data, overflow);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (char_valid !== 1'b0 || sim_done !== 1'b0) begin
      errors++; $display("FAIL pending_discard got valid=%0b done=%0b want 0/0", char_valid, sim_done);
    end
  endtask

  task automatic test_watchdog();
    logic [31:0] rd;
`ifdef SIM_MAILBOX_WATCHDOG_EN
    do_reset();
    repeat (99) @(negedge CLK);
    checks++;
    if (sim_done !== 1'b0) begin errors++; $display("FAIL wdog_early got done=%0b want 0", sim_done); end
    @(negedge CLK);
    checks++;
    if ({sim_done, sim_pass, sim_code} !== {1'b1, 1'b0, 16'hDEAD}) begin
      errors++; $display("FAIL wdog_expire got done=%0b pass=%0b code=%h want 1/0/DEAD", sim_done, sim_pass, sim_code);
    end
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'hA000_DEAD) begin errors++; $display("FAIL wdog_status got %h want A000DEAD", rd); end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      repeat (47) @(negedge CLK);
      bus_write(32'hC, 32'h0);
    end
    checks++;
    if (sim_done !== 1'b0) begin errors++; $display("FAIL wdog_kick got done=%0b want 0", sim_done); end
`else
    do_reset();
    repeat (150) @(negedge CLK);
    checks++;
    if (sim_done !== 1'b0) begin errors++; $display("FAIL no_wdog got done=%0b want 0", sim_done); end
    bus_read(32'h4, rd);
    checks++;
    if (rd !== 32'h0000_0000) begin errors++; $display("FAIL no_wdog_status got %h want 00000000", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_console();
    test_overflow();
    test_result_pass();
    test_result_fail_and_reset();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
